minimips_inst_player: RTL
=========================

Name: minimips_inst_player

Overview:
Synthesisable instruction sequencer that replaces hand-written bench stimulus on the minimips outer_inst/en inputs. A program of up to DEPTH instructions is loaded through a valid/ready port. The program is then replayed to the CPU one instruction per cycle, either once, N times, or forever. Replay supports stall, stop and optional bit reversal. It sits between a host/bench loader and minimips, sharing the CPU clock and reset.

Parameters:
DEPTH, 16, program buffer entries (power of two, >=2)
INST_W, 32, instruction width (matches inst_t)
ITER_W, 8, width of iteration count/limit
REVERSE, 1, 1 = apply mips_cpu_pkg reverse() to each instruction on output; 0 = pass through

Ports:
cpu_clk_50M  in  1  CPU clock
cpu_rst_n  in  1  asynchronous active-low reset
ld_valid  in  1  loader offers ld_inst
ld_ready  out  1  buffer accepts ld_inst this cycle
ld_inst  in  INST_W  instruction to append
clear  in  1  IDLE only: empty program buffer
start  in  1  IDLE only: begin replay
stop  in  1  RUN only: abort replay
stall  in  1  RUN only: hold current instruction
n_iter  in  ITER_W  passes to run, sampled at start; 0 = infinite
en  out  1  to minimips en
outer_inst  out  INST_W  to minimips outer_inst
busy  out  1  state is RUN
done  out  1  one-cycle pulse on normal completion
prog_len  out  $clog2(DEPTH)+1  instructions loaded
iter_cnt  out  ITER_W  completed passes in current/last run

Behaviour:
- Reset (async, cpu_rst_n=0):
  - state=IDLE.
  - wr_ptr, rd_ptr, prog_len, iter_cnt all 0.
  - en=0, outer_inst=0, done=0, busy=0.
  - Buffer contents are don't-care.
- States are IDLE, RUN, DONE. All outputs except ld_ready are registered.
- IDLE, load path:
  - ld_ready = (state==IDLE) & (prog_len<DEPTH) & !start & !clear.
  - On ld_valid&ld_ready: mem[prog_len] <= ld_inst and prog_len++.
  - When full (prog_len==DEPTH), ld_ready=0 and extra offers are not accepted.
- IDLE, clear: prog_len<=0 next cycle. It has priority over load. It does not affect iter_cnt.
- IDLE, start:
  - Priority is clear > start > load.
  - If prog_len==0, start is ignored and the block stays IDLE.
  - Otherwise: latch n_iter, rd_ptr<=0, iter_cnt<=0, go to RUN.
  - Latency: mem[0] appears on outer_inst with en=1 in the cycle after start is sampled.
- RUN, each cycle without stall/stop:
  - outer_inst <= REVERSE ? reverse(mem[rd_ptr]) : mem[rd_ptr]; en <= 1.
  - If rd_ptr != prog_len-1: rd_ptr++.
  - Else (end of pass): iter_cnt++, then:
    - if latched n_iter==0 or iter_cnt+1 < n_iter: rd_ptr<=0 and the next pass continues with no bubble;
    - otherwise go to DONE.
- iter_cnt saturates at all-ones in infinite mode; replay continues.
- RUN, stall=1: en<=0, outer_inst holds, rd_ptr holds. stall is ignored outside RUN.
- RUN, stop=1: takes priority over stall.
  - Next cycle: state=IDLE, en=0, outer_inst=0, no done pulse.
  - iter_cnt keeps the number of completed passes.
- DONE: lasts one cycle; done=1, en=0, outer_inst=0; then goes to IDLE. start is ignored in DONE.
- prog_len==1: the single instruction repeats each cycle for n_iter cycles.
- The buffer is retained across runs; a new start replays it unchanged.
- Reset mid-run: outputs return to reset values immediately (async); the program is lost (prog_len=0).

Decomposition:
- mips_cpu_pkg already provides inst_t, word_t and reverse().
- Add to mips_cpu_pkg:
  - player_state_t enum {PL_IDLE, PL_RUN, PL_DONE};
  - localparam inst_t INST_NOP = '0.
- Sub-module inst_buf: DEPTH x INST_W register file, one synchronous write port and one combinational read port, no reset on storage.

Test Plan:
1. Load 5 instructions (ADDIU t0->t1 127, SW t1->16, ADDIU t1->t2 127, LW 16->t4, ADDIU t2->t3 127), n_iter=2, start -> en=1 for 10 consecutive cycles with the sequence repeated twice (bit-reversed when REVERSE=1), then done pulses once, iter_cnt=2, en=0.
2. Same program, n_iter=0, run 23 cycles, then stop -> no done; en=0 next cycle; iter_cnt=4; state IDLE.
3. Stall asserted for 3 cycles during instruction index 2 -> outer_inst holds index-2 value, en=0 for those 3 cycles; sequence resumes at index 3 with no instruction skipped or repeated.
4. Offer DEPTH+2 instructions back-to-back -> exactly DEPTH accepted, ld_ready=0 after, prog_len=DEPTH; clear -> prog_len=0; start with empty buffer -> stays IDLE, en=0.
5. Same cycle: start=1, ld_valid=1 in IDLE with prog_len=3 -> load not accepted (prog_len stays 3); replay begins next cycle.
6. Assert cpu_rst_n=0 asynchronously mid-RUN -> en=0, outer_inst=0, busy=0 before the next clock edge; after release, prog_len=0 and the block idles.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared minimips types plus the instruction player's state type.
//   inst_t / word_t  : 32-bit instruction / data word
//   reverse()        : bit reversal of an instruction word
//   player_state_t   : minimips_inst_player FSM states
//   INST_NOP         : all-zero instruction driven while the player is idle
package mips_cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] inst_t;

    function automatic inst_t reverse(input inst_t x);
        inst_t r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        PL_IDLE,
        PL_RUN,
        PL_DONE
    } player_state_t;

    localparam inst_t INST_NOP = '0;

endpackage

// File: rtl/minimips_inst_player_inst_buf.sv
// Program storage for minimips_inst_player.
//   clk   : write clock
//   we    : write enable, waddr/wdata : synchronous write port
//   raddr : combinational read address, rdata : read data
// Storage carries no reset; contents are meaningless until written.
module inst_buf #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/minimips_inst_player.sv
// Instruction sequencer feeding minimips outer_inst/en.
//   cpu_clk_50M, cpu_rst_n       : clock, async active-low reset
//   ld_valid/ld_ready/ld_inst    : program load handshake (IDLE only)
//   clear, start                 : IDLE controls (clear > start > load)
//   stop, stall                  : RUN controls (stop > stall)
//   n_iter                       : pass count sampled at start, 0 = forever
//   en, outer_inst               : registered drive into minimips
//   busy, done                   : RUN indication, completion pulse
//   prog_len, iter_cnt           : loaded length, completed passes
module minimips_inst_player
    import mips_cpu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int INST_W  = 32,
    parameter int ITER_W  = 8,
    parameter bit REVERSE = 1'b1,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [INST_W-1:0] ld_inst,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              stall,
    input  logic [ITER_W-1:0] n_iter,
    output logic              en,
    output logic [INST_W-1:0] outer_inst,
    output logic              busy,
    output logic              done,
    output logic [PW-1:0]     prog_len,
    output logic [ITER_W-1:0] iter_cnt
);

    player_state_t     state, state_n;
    logic [AW-1:0]     rd_ptr, rd_ptr_n, cur_ptr;
    logic [PW-1:0]     prog_len_n;
    logic [ITER_W-1:0] iter_n, lim_q, lim_n, cur_iter, cur_lim, iter_sat;
    logic              fin, fin_n, en_n, we, do_step, last_slot, pass_final;
    logic [INST_W-1:0] inst_n, rd_data, rd_word;

    inst_buf #(.DEPTH(DEPTH), .INST_W(INST_W)) u_buf (
        .clk   (cpu_clk_50M),
        .we    (we),
        .waddr (prog_len[AW-1:0]),
        .wdata (ld_inst),
        .raddr (cur_ptr),
        .rdata (rd_data)
    );

    if (REVERSE) begin : g_rev
        assign rd_word = INST_W'(reverse(inst_t'(rd_data)));
    end else begin : g_pass
        assign rd_word = rd_data;
    end

    assign ld_ready = (state == PL_IDLE) && (prog_len < PW'(DEPTH)) && !start && !clear;
    assign busy     = (state == PL_RUN);
    assign done     = (state == PL_DONE);

    // The start edge already emits mem[0], so it steps as if rd_ptr=0,
    // iter_cnt=0 and the limit were the live n_iter.
    assign cur_ptr  = (state == PL_IDLE) ? '0 : rd_ptr;
    assign cur_iter = (state == PL_IDLE) ? '0 : iter_cnt;
    assign cur_lim  = (state == PL_IDLE) ? n_iter : lim_q;

    assign last_slot  = ({1'b0, cur_ptr} == prog_len - PW'(1));
    assign iter_sat   = (&cur_iter) ? cur_iter : cur_iter + 1'b1;
    assign pass_final = (cur_lim != '0) &&
                        (({1'b0, cur_iter} + 1'b1) >= {1'b0, cur_lim});

    always_comb begin
        state_n    = state;
        rd_ptr_n   = rd_ptr;
        prog_len_n = prog_len;
        iter_n     = iter_cnt;
        lim_n      = lim_q;
        fin_n      = fin;
        en_n       = en;
        inst_n     = outer_inst;
        we         = 1'b0;
        do_step    = 1'b0;
        case (state)
            PL_IDLE: begin
                en_n   = 1'b0;
                inst_n = '0;
                if (clear) begin
                    prog_len_n = '0;
                end else if (start && prog_len != '0) begin
                    lim_n   = n_iter;
                    iter_n  = '0;
                    fin_n   = 1'b0;
                    state_n = PL_RUN;
                    do_step = 1'b1;
                end else if (ld_valid && ld_ready) begin
                    we         = 1'b1;
                    prog_len_n = prog_len + 1'b1;
                end
            end
            PL_RUN: begin
                if (stop) begin
                    state_n = PL_IDLE;
                    en_n    = 1'b0;
                    inst_n  = '0;
                    fin_n   = 1'b0;
                end else if (stall) begin
                    en_n = 1'b0;
                end else if (fin) begin
                    // last instruction of the final pass has been shown
                    state_n = PL_DONE;
                    en_n    = 1'b0;
                    inst_n  = '0;
                    fin_n   = 1'b0;
                end else begin
                    do_step = 1'b1;
                end
            end
            PL_DONE: begin
                state_n = PL_IDLE;
                en_n    = 1'b0;
                inst_n  = '0;
            end
            default: begin
                state_n = PL_IDLE;
                en_n    = 1'b0;
                inst_n  = '0;
            end
        endcase
        if (do_step) begin
            inst_n = rd_word;
            en_n   = 1'b1;
            if (last_slot) begin
                iter_n   = iter_sat;
                rd_ptr_n = '0;
                fin_n    = pass_final;
            end else begin
                rd_ptr_n = cur_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state      <= PL_IDLE;
            rd_ptr     <= '0;
            prog_len   <= '0;
            iter_cnt   <= '0;
            lim_q      <= '0;
            fin        <= 1'b0;
            en         <= 1'b0;
            outer_inst <= '0;
        end else begin
            state      <= state_n;
            rd_ptr     <= rd_ptr_n;
            prog_len   <= prog_len_n;
            iter_cnt   <= iter_n;
            lim_q      <= lim_n;
            fin        <= fin_n;
            en         <= en_n;
            outer_inst <= inst_n;
        end
    end

endmodule
